// File: rtl/row_buffer_scheduler_if.sv
// Handshake and bus bundle for row_buffer_scheduler: sync-manager inputs, buffer write
// strobes and the read-side valid/done handshake with the matrix output path.
interface row_buffer_scheduler_if #(
  parameter int unsigned AW = 11,
  parameter int unsigned LW = 11
) ();
  logic          I_new_frame;
  logic          I_rgb_de;
  logic          I_image_valid;
  logic [AW-1:0] I_image_width;
  logic          O_wr_en;
  logic          O_wr_buf;
  logic [AW-1:0] O_wr_addr;
  logic          O_rd_valid;
  logic          O_rd_buf;
  logic [LW-1:0] O_rd_line;
  logic          I_rd_done;
  logic          O_frame_start;
  logic [15:0]   O_drop_count;
  logic          O_len_err;

  // Upstream/consumer side.
  modport master (
    output I_new_frame, I_rgb_de, I_image_valid, I_image_width, I_rd_done,
    input  O_wr_en, O_wr_buf, O_wr_addr, O_rd_valid, O_rd_buf, O_rd_line,
    input  O_frame_start, O_drop_count, O_len_err
  );

  // Scheduler side.
  modport slave (
    input  I_new_frame, I_rgb_de, I_image_valid, I_image_width, I_rd_done,
    output O_wr_en, O_wr_buf, O_wr_addr, O_rd_valid, O_rd_buf, O_rd_line,
    output O_frame_start, O_drop_count, O_len_err
  );
endinterface

// File: rtl/row_buffer_scheduler.sv
// Row buffer scheduler: captures one active row out of every ROW_STEP into a free half of a
// ping-pong line buffer pair, presents completed halves to the consumer, and counts rows
// dropped because both halves were still occupied.
// Optional feature: define ROW_SCHED_LEN_CHECK_EN to reject captured rows whose pixel count
// differs from I_image_width (O_len_err pulses instead of a commit).
module row_buffer_scheduler #(
  parameter int unsigned MAX_WIDTH  = 1920,
  parameter int unsigned MAX_HEIGHT = 1080,
  parameter int unsigned ROW_STEP   = 8,
  parameter int unsigned ROW_OFFSET = 0
) (
  input logic                   I_rgb_clk,
  input logic                   I_rst,
  row_buffer_scheduler_if.slave bus
);
  localparam int unsigned AW = $clog2(MAX_WIDTH);
  localparam int unsigned LW = $clog2(MAX_HEIGHT);
  localparam int unsigned PW = (ROW_STEP > 1) ? $clog2(ROW_STEP) : 1;
  localparam int unsigned CW = $clog2(MAX_WIDTH + 1);

  localparam logic [PW-1:0] PhaseLast = PW'(ROW_STEP - 1);
  localparam logic [PW-1:0] PhaseCap  = PW'(ROW_OFFSET);
  localparam logic [LW-1:0] LineLast  = LW'(MAX_HEIGHT - 1);
  localparam logic [CW-1:0] CntFull   = CW'(MAX_WIDTH);

  typedef enum logic [2:0] {
    StIdle, StWaitFrame, StWaitLine, StCapture, StSkip
  } state_e;

  state_e        state_q;
  logic          de_q;
  logic [PW-1:0] phase_q;
  logic [LW-1:0] line_q;
  logic          wr_sel_q;
  logic          rd_sel_q;
  logic [1:0]    full_q;
  logic [LW-1:0] line_of_q [2];
  logic          wr_en_q;
  logic [AW-1:0] wr_addr_q;
  logic [CW-1:0] pix_cnt_q;
  logic          frame_start_q;
  logic [15:0]   drop_cnt_q;
`ifdef ROW_SCHED_LEN_CHECK_EN
  logic          len_err_q;
`endif

  logic          de_rise;
  logic          de_fall;
  logic          rd_fire;
  logic          capture_ok;
  logic          len_ok;
  logic          commit;
  logic [PW-1:0] phase_adv;
  logic [LW-1:0] line_adv;

  // Edge detection, read handshake, row advance and the commit decision.
  always_comb begin
    de_rise    = bus.I_rgb_de & ~de_q;
    de_fall    = ~bus.I_rgb_de & de_q;
    rd_fire    = bus.I_rd_done & full_q[rd_sel_q];
    phase_adv  = (phase_q == PhaseLast) ? '0 : phase_q + 1'b1;
    line_adv   = (line_q == LineLast) ? line_q : line_q + 1'b1;
    capture_ok = (phase_q == PhaseCap) & ~full_q[wr_sel_q];
`ifdef ROW_SCHED_LEN_CHECK_EN
    len_ok     = (pix_cnt_q == CW'(bus.I_image_width));
`else
    len_ok     = 1'b1;
`endif
    // A row lost to image_valid dropping is never committed.
    commit     = (state_q == StCapture) & de_fall & bus.I_image_valid & len_ok;
  end

  // Frame/row FSM, write-address generation and ping-pong buffer ownership.
  always_ff @(posedge I_rgb_clk) begin
    if (I_rst) begin
      state_q       <= StIdle;
      de_q          <= 1'b0;
      phase_q       <= '0;
      line_q        <= '0;
      wr_sel_q      <= 1'b0;
      rd_sel_q      <= 1'b0;
      full_q        <= '0;
      line_of_q[0]  <= '0;
      line_of_q[1]  <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      pix_cnt_q     <= '0;
      frame_start_q <= 1'b0;
      drop_cnt_q    <= '0;
`ifdef ROW_SCHED_LEN_CHECK_EN
      len_err_q     <= 1'b0;
`endif
    end else begin
      de_q          <= bus.I_rgb_de;
      wr_en_q       <= 1'b0;
      frame_start_q <= 1'b0;
`ifdef ROW_SCHED_LEN_CHECK_EN
      len_err_q     <= 1'b0;
`endif
      // Commit and release always address different halves, so both may land together.
      if (rd_fire) begin
        full_q[rd_sel_q] <= 1'b0;
        rd_sel_q         <= ~rd_sel_q;
      end
      if (commit) begin
        full_q[wr_sel_q]    <= 1'b1;
        line_of_q[wr_sel_q] <= line_q;
        wr_sel_q            <= ~wr_sel_q;
      end

      if (state_q != StIdle && !bus.I_image_valid) begin
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (bus.I_image_valid) state_q <= StWaitFrame;
          end
          StWaitFrame: begin
          end
          StWaitLine: begin
            if (de_rise) begin
              if (capture_ok) begin
                state_q   <= StCapture;
                wr_en_q   <= 1'b1;
                wr_addr_q <= '0;
                pix_cnt_q <= CW'(1);
              end else begin
                state_q <= StSkip;
                if (phase_q == PhaseCap && drop_cnt_q != 16'hFFFF) begin
                  drop_cnt_q <= drop_cnt_q + 16'd1;
                end
              end
            end
          end
          StCapture: begin
            if (de_fall) begin
`ifdef ROW_SCHED_LEN_CHECK_EN
              if (!len_ok) len_err_q <= 1'b1;
`endif
              phase_q <= phase_adv;
              line_q  <= line_adv;
              state_q <= StWaitLine;
            end else if (bus.I_rgb_de && pix_cnt_q != CntFull) begin
              // Pixels past the last address are discarded; the address holds.
              wr_en_q   <= 1'b1;
              wr_addr_q <= AW'(pix_cnt_q);
              pix_cnt_q <= pix_cnt_q + 1'b1;
            end
          end
          StSkip: begin
            if (de_fall) begin
              phase_q <= phase_adv;
              line_q  <= line_adv;
              state_q <= StWaitLine;
            end
          end
          default: state_q <= StIdle;
        endcase

        // Frame start overrides the row in progress; a same-cycle commit has already landed.
        if (state_q != StIdle && bus.I_new_frame) begin
          phase_q       <= '0;
          line_q        <= '0;
          state_q       <= StWaitLine;
          wr_en_q       <= 1'b0;
          frame_start_q <= 1'b1;
        end
      end
    end
  end

`ifdef ROW_SCHED_LEN_CHECK_EN
  assign bus.O_len_err = len_err_q;
`else
  logic unused_width;
  assign unused_width  = ^bus.I_image_width;
  assign bus.O_len_err = 1'b0;
`endif

  assign bus.O_wr_en       = wr_en_q;
  assign bus.O_wr_buf      = wr_sel_q;
  assign bus.O_wr_addr     = wr_addr_q;
  assign bus.O_rd_valid    = full_q[rd_sel_q];
  assign bus.O_rd_buf      = rd_sel_q;
  assign bus.O_rd_line     = line_of_q[rd_sel_q];
  assign bus.O_frame_start = frame_start_q;
  assign bus.O_drop_count  = drop_cnt_q;
endmodule

// File: tb/tb_row_buffer_scheduler.sv
// Bench for row_buffer_scheduler. The reference model works per row: it decides from
// phase/line and the number of occupied buffers whether a row is captured, dropped or skipped,
// and tracks buffers as commit/consume counts plus a queue of committed line indices.
module tb_row_buffer_scheduler;
  localparam int unsigned MW   = 96;
  localparam int unsigned MH   = 20;
  localparam int unsigned STEP = 3;
  localparam int unsigned OFF  = 1;
  localparam int unsigned AW   = $clog2(MW);
  localparam int unsigned LW   = $clog2(MH);
`ifdef ROW_SCHED_LEN_CHECK_EN
  localparam bit LenChk = 1'b1;
`else
  localparam bit LenChk = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  row_buffer_scheduler_if #(.AW(AW), .LW(LW)) bus ();

  row_buffer_scheduler #(
    .MAX_WIDTH (MW),
    .MAX_HEIGHT(MH),
    .ROW_STEP  (STEP),
    .ROW_OFFSET(OFF)
  ) dut (
    .I_rgb_clk(clk),
    .I_rst    (rst),
    .bus      (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  bit active;
  int ph, ln, commits, consumed, drops, width;
  int line_log[$];
  bit exp_fs, exp_le;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    active = 0; ph = 0; ln = 0; commits = 0; consumed = 0; drops = 0;
    exp_fs = 0; exp_le = 0;
    line_log.delete();
  endtask

  task automatic check_common();
    int cnt;
    cnt = commits - consumed;
    chk("wr_buf", bus.O_wr_buf, commits % 2);
    chk("rd_valid", bus.O_rd_valid, cnt > 0);
    chk("rd_buf", bus.O_rd_buf, consumed % 2);
    if (cnt > 0) chk("rd_line", bus.O_rd_line, line_log[consumed]);
    chk("drop_count", bus.O_drop_count, drops);
    chk("frame_start", bus.O_frame_start, exp_fs);
    chk("len_err", bus.O_len_err, exp_le);
    exp_fs = 0;
    exp_le = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".wr_en"}, bus.O_wr_en, 0);
    chk({tag, ".wr_buf"}, bus.O_wr_buf, 0);
    chk({tag, ".wr_addr"}, bus.O_wr_addr, 0);
    chk({tag, ".rd_valid"}, bus.O_rd_valid, 0);
    chk({tag, ".rd_buf"}, bus.O_rd_buf, 0);
    chk({tag, ".rd_line"}, bus.O_rd_line, 0);
    chk({tag, ".frame_start"}, bus.O_frame_start, 0);
    chk({tag, ".drop_count"}, bus.O_drop_count, 0);
    chk({tag, ".len_err"}, bus.O_len_err, 0);
  endtask

  task automatic gap(input int n);
    bus.I_rgb_de = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      chk("gap_wr_en", bus.O_wr_en, 0);
      check_common();
    end
  endtask

  task automatic consume();
    bit v;
    v = (commits - consumed) > 0;
    bus.I_rgb_de  = 1'b0;
    bus.I_rd_done = 1'b1;
    tick();
    bus.I_rd_done = 1'b0;
    if (v) consumed++;
    chk("cons_wr_en", bus.O_wr_en, 0);
    check_common();
  endtask

  task automatic enable();
    bus.I_image_valid = 1'b1;
    gap(2);
  endtask

  task automatic start_frame();
    bus.I_rgb_de    = 1'b0;
    bus.I_new_frame = 1'b1;
    tick();
    bus.I_new_frame = 1'b0;
    active = 1; ph = 0; ln = 0; exp_fs = 1;
    chk("sf_wr_en", bus.O_wr_en, 0);
    check_common();
  endtask

  // One active row of len pixels followed by its de-fall cycle.
  task automatic row(input int len, input int abort_at, input int invalid_at,
                     input bit done_fall, input bit nf_fall);
    bit sel, cap, dead, v;
    int npix;
    sel = active && (ph == OFF);
    cap = sel && ((commits - consumed) < 2);
    if (sel && !cap && drops < 65535) drops++;
    dead = !active;
    bus.I_image_width = width[AW-1:0];
    for (int p = 0; p < len; p++) begin
      bus.I_rgb_de    = 1'b1;
      bus.I_new_frame = (p == abort_at);
      if (p == invalid_at) bus.I_image_valid = 1'b0;
      tick();
      bus.I_new_frame = 1'b0;
      if (p == abort_at || p == invalid_at) begin
        if (!dead) begin
          if (p == invalid_at) active = 0;
          else begin
            ph = 0; ln = 0; exp_fs = 1;
          end
        end
        dead = 1;
      end else if (!dead && cap && p < MW) begin
        chk("wr_en", bus.O_wr_en, 1);
        chk("wr_addr", bus.O_wr_addr, p);
      end else begin
        chk("wr_en_off", bus.O_wr_en, 0);
        if (!dead && cap) chk("wr_addr_sat", bus.O_wr_addr, MW - 1);
      end
      check_common();
    end
    v = (commits - consumed) > 0;
    bus.I_rgb_de    = 1'b0;
    bus.I_rd_done   = done_fall;
    bus.I_new_frame = nf_fall;
    tick();
    bus.I_rd_done   = 1'b0;
    bus.I_new_frame = 1'b0;
    if (done_fall && v) consumed++;
    if (!dead) begin
      if (cap) begin
        npix = (len < MW) ? len : MW;
        if (LenChk && npix != width) exp_le = 1;
        else begin
          line_log.push_back(ln);
          commits++;
        end
      end
      ph = (ph + 1) % STEP;
      ln = (ln + 1 < MH) ? ln + 1 : MH - 1;
    end
    if (nf_fall && active) begin
      ph = 0; ln = 0; exp_fs = 1;
    end
    chk("fall_wr_en", bus.O_wr_en, 0);
    check_common();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, ab;
    bit df, nf;
    model_reset();
    width = 64;
    rst = 1'b1;
    bus.I_new_frame = 1'b0; bus.I_rgb_de = 1'b0; bus.I_image_valid = 1'b0;
    bus.I_image_width = '0; bus.I_rd_done = 1'b0;
    repeat (3) tick();
    chk_zero("reset");
    rst = 1'b0;

    // Idle / waiting for frame: done ignored, rows ignored.
    consume();
    row(10, -1, -1, 0, 0);
    enable();
    row(10, -1, -1, 0, 0);
    start_frame();
    gap(3);

    // 64-px rows, consumer answers 10 cycles after valid; lines saturate at MH-1.
    for (int r = 0; r < 26; r++) begin
      row(64, -1, -1, 0, 0);
      if (commits - consumed > 0) begin
        gap(10);
        consume();
      end
    end

    // No consumer: two captures then drops.
    start_frame();
    gap(2);
    for (int r = 0; r < 9; r++) row(64, -1, -1, 0, 0);
    gap(2);
    while (commits - consumed > 0) consume();

    // New frame at pixel 20 of a captured row.
    start_frame();
    gap(2);
    row(64, -1, -1, 0, 0);
    row(64, 20, -1, 0, 0);
    gap(2);
    for (int r = 0; r < 3; r++) row(64, -1, -1, 0, 0);
    while (commits - consumed > 0) consume();

    // Row longer than MAX_WIDTH.
    while (ph != OFF) row(8, -1, -1, 0, 0);
    row(MW + 10, -1, -1, 0, 0);
    gap(2);
    while (commits - consumed > 0) consume();

    // Commit, release and frame start all on the de-fall cycle.
    while (ph != OFF) row(8, -1, -1, 0, 0);
    row(64, -1, -1, 0, 0);
    while (ph != OFF) row(8, -1, -1, 0, 0);
    row(64, -1, -1, 1, 1);
    gap(2);

    // image_valid drops mid-row: back to idle, needs valid and a new frame.
    while (ph != OFF) row(8, -1, -1, 0, 0);
    row(40, -1, 10, 0, 0);
    gap(2);
    row(20, -1, -1, 0, 0);
    enable();
    row(20, -1, -1, 0, 0);
    start_frame();
    gap(1);

    // Randomized rows.
    for (int r = 0; r < 80; r++) begin
      if (!LenChk) width = $urandom_range(0, MW - 1);
      len = $urandom_range(1, MW + 6);
      if ($urandom_range(0, 2) == 0) len = 64;
      ab = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      df = ($urandom_range(0, 3) == 0);
      nf = (ab < 0) && ($urandom_range(0, 15) == 0);
      row(len, ab, -1, df, nf);
      if ($urandom_range(0, 1) == 0) gap($urandom_range(1, 4));
      if ($urandom_range(0, 2) == 0) consume();
    end
    width = 64;

    // Reset in the middle of a captured row with one buffer occupied.
    while (commits - consumed > 0) consume();
    while (ph != OFF) row(8, -1, -1, 0, 0);
    row(64, -1, -1, 0, 0);
    while (ph != OFF) row(8, -1, -1, 0, 0);
    bus.I_image_width = width[AW-1:0];
    bus.I_rgb_de = 1'b1;
    for (int p = 0; p < 6; p++) begin
      tick();
      chk("pre_rst_wr_en", bus.O_wr_en, 1);
      chk("pre_rst_wr_addr", bus.O_wr_addr, p);
      check_common();
    end
    rst = 1'b1;
    tick();
    chk_zero("rst_mid_row");
    rst = 1'b0;
    bus.I_rgb_de = 1'b0;
    model_reset();
    gap(2);
    row(20, -1, -1, 0, 0);
    start_frame();
    gap(1);
    for (int r = 0; r < 3; r++) row(64, -1, -1, 0, 0);
    gap(3);
    while (commits - consumed > 0) consume();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
